ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_pkg.sv | 19 +
 rtl/ram_port_arbiter_if.sv | 19 +
 rtl/ram_port_arbiter_dualport_ram.sv | 24 ++
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and the port-stage record for the two-port RAM arbiter.
package ram_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;
    localparam int CID_W      = 3;   // wide enough for up to 8 clients

    // One captured access waiting for its RAM edge.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic [CID_W-1:0]      cid;
    } port_stage_t;

    localparam port_stage_t STAGE_IDLE = '0;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client-side bus of the RAM arbiter; master = the clients, slave = the arbiter.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
);
    logic [NUM_CLIENTS-1:0]        req;
    logic [NUM_CLIENTS-1:0]        we;
    logic [NUM_CLIENTS*ADDR_W-1:0] addr;
    logic [NUM_CLIENTS*DATA_W-1:0] wdata;
    logic [NUM_CLIENTS-1:0]        gnt;
    logic [NUM_CLIENTS-1:0]        rvalid;
    logic [NUM_CLIENTS*DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter_dualport_ram.sv
// Dual-port RAM with synchronous read-first ports; on a same-address double write port B wins.
module dualport_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              w_a,
    input  logic              w_b,
    input  logic [ADDR_W-1:0] add_a,
    input  logic [ADDR_W-1:0] add_b,
    input  logic [DATA_W-1:0] d_in_a,
    input  logic [DATA_W-1:0] d_in_b,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (w_a) mem[add_a] <= d_in_a;
        if (w_b) mem[add_b] <= d_in_b;
        d_out_a <= mem[add_a];
        d_out_b <= mem[add_b];
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter granting up to two clients per cycle onto a dual-port RAM.
// Define RAM_ARB_COLLISION_EN to defer the second winner on a same-address write conflict.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);
    logic [CID_W-1:0]       ptr;
    logic [NUM_CLIENTS-1:0] first_oh;
    logic [NUM_CLIENTS-1:0] second_oh;
    logic [NUM_CLIENTS-1:0] rv;
    logic [ADDR_W-1:0]      addr_c  [NUM_CLIENTS];
    logic [DATA_W-1:0]      wdata_c [NUM_CLIENTS];
    logic [DATA_W-1:0]      rdata_q [NUM_CLIENTS];
    logic [DATA_W-1:0]      rd_cur  [NUM_CLIENTS];
    port_stage_t            cand_a, cand_b, stage_a, stage_b;
    logic                   collide;
    logic                   pend_a, pend_b;
    logic [CID_W-1:0]       pcid_a, pcid_b, last_cid;
    logic [DATA_W-1:0]      d_out_a, d_out_b;
    int                     best1, best2;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_slice
        assign addr_c[i]  = bus.addr[i*ADDR_W +: ADDR_W];
        assign wdata_c[i] = bus.wdata[i*DATA_W +: DATA_W];
        assign bus.rdata[i*DATA_W +: DATA_W] = rd_cur[i];
    end

    // Distance of a client from the pointer in upward, wrapping search order.
    function automatic int rank_of(input int idx, input logic [CID_W-1:0] p);
        return (idx + NUM_CLIENTS - int'(p)) % NUM_CLIENTS;
    endfunction

    always_comb begin
        best1 = NUM_CLIENTS;
        best2 = NUM_CLIENTS;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (bus.req[i]) begin
                if (rank_of(i, ptr) < best1) begin
                    best2 = best1;
                    best1 = rank_of(i, ptr);
                end else if (rank_of(i, ptr) < best2) begin
                    best2 = rank_of(i, ptr);
                end
            end
        end
        first_oh  = '0;
        second_oh = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            first_oh[i]  = bus.req[i] && (rank_of(i, ptr) == best1);
            second_oh[i] = bus.req[i] && (rank_of(i, ptr) == best2);
        end
    end

    always_comb begin
        cand_a  = STAGE_IDLE;
        cand_b  = STAGE_IDLE;
        collide = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (first_oh[i])
                cand_a = '{valid: 1'b1, we: bus.we[i], addr: addr_c[i],
                           wdata: wdata_c[i], cid: CID_W'(i)};
            if (second_oh[i])
                cand_b = '{valid: 1'b1, we: bus.we[i], addr: addr_c[i],
                           wdata: wdata_c[i], cid: CID_W'(i)};
        end
`ifdef RAM_ARB_COLLISION_EN
        collide = cand_a.valid && cand_b.valid && (cand_a.addr == cand_b.addr) &&
                  (cand_a.we || cand_b.we);
`endif
        if (collide) cand_b = STAGE_IDLE;
    end

    assign bus.gnt  = rst ? '0 : (first_oh | (second_oh & {NUM_CLIENTS{!collide}}));
    assign last_cid = cand_b.valid ? cand_b.cid : cand_a.cid;

    // Stage captures on the grant edge; the RAM acts on the next edge, then the read flag follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            stage_a <= STAGE_IDLE;
            stage_b <= STAGE_IDLE;
            pend_a  <= 1'b0;
            pend_b  <= 1'b0;
            pcid_a  <= '0;
            pcid_b  <= '0;
        end else begin
            pend_a  <= stage_a.valid && !stage_a.we;
            pend_b  <= stage_b.valid && !stage_b.we;
            pcid_a  <= stage_a.cid;
            pcid_b  <= stage_b.cid;
            stage_a <= cand_a;
            stage_b <= cand_b;
            if (cand_a.valid)
                ptr <= CID_W'((int'(last_cid) + 1) % NUM_CLIENTS);
        end
    end

    always_comb begin
        rv = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rd_cur[i] = rdata_q[i];
            if (pend_b && (pcid_b == CID_W'(i))) begin
                rv[i]     = 1'b1;
                rd_cur[i] = d_out_b;
            end
            if (pend_a && (pcid_a == CID_W'(i))) begin
                rv[i]     = 1'b1;
                rd_cur[i] = d_out_a;
            end
        end
    end

    assign bus.rvalid = rv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLIENTS; i++) rdata_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++)
                if (rv[i]) rdata_q[i] <= rd_cur[i];
        end
    end

    dualport_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .w_a     (stage_a.valid && stage_a.we),
        .w_b     (stage_b.valid && stage_b.we),
        .add_a   (stage_a.addr),
        .add_b   (stage_b.addr),
        .d_in_a  (stage_a.wdata),
        .d_in_b  (stage_b.wdata),
        .d_out_a (d_out_a),
        .d_out_b (d_out_b)
    );
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, hand sequences, and random traffic vs a reference model.
module tb_ram_port_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(4), .DATA_W(8)) bus ();

    ram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_W(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] w,
                         input logic [15:0] a, input logic [31:0] d);
        bus.req   = r;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    typedef struct {
        bit         we;
        int         cid;
        logic [3:0] addr;
        logic [7:0] d;
    } op_t;

    // Reference model state
    logic [7:0] m_mem [16];
    bit         m_known [16];
    int         m_ptr;
    op_t        m_stage [$];
    op_t        m_next [$];
    op_t        op;
    bit [3:0]   m_rv, new_rv;
    logic [7:0] m_rd [N];
    bit         m_rd_known [N];
    logic [7:0] m_hold [N];
    bit         m_hold_known [N];
    int         order [$];
    int         c;
    bit         clash;
    logic [3:0] exp_gnt;
    logic [7:0] exp_b;
    bit         exp_known;

    bit [3:0]    p_req, p_gnt;
    logic [3:0]  cur_req, cur_we;
    logic [15:0] cur_addr;
    logic [31:0] cur_wd;
    int          gcnt [N];

    initial begin
        vecs[0] = '{4'b0001, 4'b0001, 16'h0001, 32'h000000B5, 4'b0001, 4'b0000, 32'h00000000};
        vecs[1] = '{4'b0001, 4'b0000, 16'h0001, 32'h00000000, 4'b0001, 4'b0000, 32'h00000000};
        vecs[2] = '{4'b0110, 4'b0110, 16'h0320, 32'h00EE5B00, 4'b0110, 4'b0000, 32'h00000000};
        vecs[3] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 4'b0001, 32'h000000B5};
        vecs[4] = '{4'b0110, 4'b0000, 16'h0320, 32'h00000000, 4'b0110, 4'b0000, 32'h000000B5};
        vecs[5] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 4'b0000, 32'h000000B5};
        vecs[6] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 4'b0110, 32'h00EE5BB5};
        vecs[7] = '{4'b0000, 4'b0000, 16'h0000, 32'h00000000, 4'b0000, 4'b0000, 32'h00EE5BB5};

        // Reset state, with every client requesting
        drive(4'b1111, 4'b0000, 16'h1111, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt", bus.gnt, 4'b0000);
            check("rst_rvalid", bus.rvalid, 4'b0000);
            check("rst_rdata", bus.rdata, 32'h0);
            step();
        end
        rst = 1'b0;

        // Single write/read and dual write/read
        for (int v = 0; v < 8; v++) begin
            drive(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            @(negedge clk);
            check($sformatf("vec%0d_gnt", v), bus.gnt, vecs[v].exp_gnt);
            check($sformatf("vec%0d_rvalid", v), bus.rvalid, vecs[v].exp_rvalid);
            check($sformatf("vec%0d_rdata", v), bus.rdata, vecs[v].exp_rdata);
            step();
        end

        // Reset in the cycle after a read handshake
        drive(4'b0001, 4'b0000, 16'h0001, 32'h0);
        @(negedge clk);
        check("mid_rd_gnt", bus.gnt, 4'b0001);
        step();
        rst = 1'b1;
        drive(4'b1111, 4'b0000, 16'h1111, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_gnt", bus.gnt, 4'b0000);
            check("mid_rst_rvalid", bus.rvalid, 4'b0000);
            check("mid_rst_rdata", bus.rdata, 32'h0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ptr0_gnt", bus.gnt, 4'b0011);
        step();
        drive(4'b0000, 4'b0000, 16'h0, 32'h0);
        @(negedge clk);
        check("post_rst_no_stale_rvalid", bus.rvalid, 4'b0000);
        step();
        @(negedge clk);
        check("post_rst_rvalid", bus.rvalid, 4'b0011);
        check("post_rst_rdata", bus.rdata[15:0], 16'hB5B5);
        step();

        // Fairness from ptr=0
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int k = 0; k < N; k++) gcnt[k] = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(4'b1111, 4'b0000, 16'h1111, 32'h0);
            else       drive(4'b0000, 4'b0000, 16'h0, 32'h0);
            @(negedge clk);
            check($sformatf("fair%0d_gnt", i), bus.gnt,
                  (i >= 8) ? 4'b0000 : ((i % 2 == 1) ? 4'b1100 : 4'b0011));
            check($sformatf("fair%0d_rvalid", i), bus.rvalid,
                  (i < 2) ? 4'b0000 : (((i - 2) % 2 == 1) ? 4'b1100 : 4'b0011));
            for (int k = 0; k < N; k++) if (bus.gnt[k]) gcnt[k]++;
            step();
        end
        for (int k = 0; k < N; k++) check($sformatf("fair_count%0d", k), gcnt[k], 4);

        // Same-address double write
        drive(4'b0011, 4'b0011, 16'h0044, 32'h0000FFEE);
        @(negedge clk);
`ifdef RAM_ARB_COLLISION_EN
        check("coll_gnt", bus.gnt, 4'b0001);
        step();
        drive(4'b0010, 4'b0010, 16'h0044, 32'h0000FFEE);
        @(negedge clk);
        check("coll_gnt_next", bus.gnt, 4'b0010);
`else
        check("coll_gnt", bus.gnt, 4'b0011);
        step();
        drive(4'b0000, 4'b0000, 16'h0, 32'h0);
        @(negedge clk);
        check("coll_gnt_next", bus.gnt, 4'b0000);
`endif
        step();
        drive(4'b0001, 4'b0000, 16'h0004, 32'h0);
        @(negedge clk);
        check("coll_rd_gnt", bus.gnt, 4'b0001);
        step();
        drive(4'b0000, 4'b0000, 16'h0, 32'h0);
        @(negedge clk);
        check("coll_rd_wait", bus.rvalid, 4'b0000);
        step();
        @(negedge clk);
        check("coll_rd_rvalid", bus.rvalid, 4'b0001);
        check("coll_rd_data", bus.rdata[7:0], 8'hFF);
        step();

        // Random traffic against the reference model
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int a = 0; a < 16; a++) m_known[a] = 1'b0;
        m_mem[1] = 8'hB5; m_known[1] = 1'b1;
        m_mem[2] = 8'h5B; m_known[2] = 1'b1;
        m_mem[3] = 8'hEE; m_known[3] = 1'b1;
        m_mem[4] = 8'hFF; m_known[4] = 1'b1;
        m_ptr = 0;
        m_stage = {};
        m_rv = '0;
        for (int k = 0; k < N; k++) begin
            m_hold[k] = 8'h00;
            m_hold_known[k] = 1'b1;
            m_rd[k] = 8'h00;
            m_rd_known[k] = 1'b0;
        end
        p_req = '0; p_gnt = '0;
        cur_req = '0; cur_we = '0; cur_addr = '0; cur_wd = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!(p_req[k] && !p_gnt[k])) begin
                    cur_req[k] = ($urandom_range(0, 99) < 55);
                    cur_we[k]  = 1'($urandom_range(0, 1));
                    cur_addr[k*4 +: 4] = 4'($urandom_range(0, 7));
                    cur_wd[k*8 +: 8]   = 8'($urandom);
                end
            end
            drive(cur_req, cur_we, cur_addr, cur_wd);

            // Winners: first two requesters in wrapping order from the pointer
            order = {};
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (cur_req[c]) order.push_back(c);
            end
            m_next = {};
            if (order.size() >= 1) begin
                op = '{cur_we[order[0]], order[0], cur_addr[order[0]*4 +: 4], cur_wd[order[0]*8 +: 8]};
                m_next.push_back(op);
            end
            if (order.size() >= 2) begin
                clash = 1'b0;
`ifdef RAM_ARB_COLLISION_EN
                clash = (cur_addr[order[0]*4 +: 4] == cur_addr[order[1]*4 +: 4]) &&
                        (cur_we[order[0]] || cur_we[order[1]]);
`endif
                if (!clash) begin
                    op = '{cur_we[order[1]], order[1], cur_addr[order[1]*4 +: 4], cur_wd[order[1]*8 +: 8]};
                    m_next.push_back(op);
                end
            end
            exp_gnt = '0;
            foreach (m_next[j]) exp_gnt[m_next[j].cid] = 1'b1;

            @(negedge clk);
            check($sformatf("rnd%0d_gnt", cyc), bus.gnt, exp_gnt);
            check($sformatf("rnd%0d_rvalid", cyc), bus.rvalid, m_rv);
            for (int k = 0; k < N; k++) begin
                exp_b     = m_rv[k] ? m_rd[k] : m_hold[k];
                exp_known = m_rv[k] ? m_rd_known[k] : m_hold_known[k];
                if (exp_known)
                    check($sformatf("rnd%0d_rdata%0d", cyc, k), bus.rdata[k*8 +: 8], exp_b);
                if (m_rv[k]) begin
                    m_hold[k] = m_rd[k];
                    m_hold_known[k] = m_rd_known[k];
                end
            end

            // RAM edge: reads see memory before this edge's writes; port B written last
            new_rv = '0;
            foreach (m_stage[j]) begin
                if (!m_stage[j].we) begin
                    new_rv[m_stage[j].cid] = 1'b1;
                    m_rd[m_stage[j].cid] = m_mem[m_stage[j].addr];
                    m_rd_known[m_stage[j].cid] = m_known[m_stage[j].addr];
                end
            end
            foreach (m_stage[j]) begin
                if (m_stage[j].we) begin
                    m_mem[m_stage[j].addr] = m_stage[j].d;
                    m_known[m_stage[j].addr] = 1'b1;
                end
            end
            m_rv = new_rv;
            m_stage = m_next;
            if (m_next.size() > 0) m_ptr = (m_next[m_next.size()-1].cid + 1) % N;
            p_req = cur_req;
            p_gnt = exp_gnt;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
